// File: rtl/a2d_scheduler_pkg.sv
// Shared types and the command-word helper for the A2D round-robin sequencer.
package a2d_pkg;

   typedef enum logic [1:0] {IDLE, CNV, GAP, RD} a2d_state_t;

   typedef enum logic [1:0] {CH_LFT, CH_RGHT, CH_BATT} a2d_chan_t;

   // ADC128S control word: the channel address sits in bits [13:11].
   function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_scheduler_if.sv
// SPI monarch request/response bundle seen by the A2D sequencer.
interface a2d_scheduler_if;
   // wrt is a 1-clk start strobe carrying cmd; the monarch answers with a 1-clk done
   // strobe and rd_data valid in that cycle. cmd stays stable from wrt until done.
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;

   modport master (output wrt, output cmd, input done, input rd_data);
   modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_scheduler_avg.sv
// One 12-bit IIR result register, new = (3*old + sample) >> 2; first sample after reset loads raw.
// Only built when A2D_AVG_EN is defined.
`ifdef A2D_AVG_EN
module a2d_avg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld,
   input  logic [11:0] sample,
   output logic [11:0] val
);

   logic        first;
   logic [13:0] acc;

   // 3*4095 + 4095 fits in 14 bits, so no overflow before the shift.
   assign acc = ({2'b00, val} * 14'd3) + {2'b00, sample};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val   <= 12'h000;
         first <= 1'b1;
      end else if (ld) begin
         val   <= first ? sample : acc[13:2];
         first <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/a2d_scheduler.sv
// Round-robin lft -> rght -> batt conversion sequencer sharing one SPI monarch.
// Define A2D_AVG_EN to replace the raw result registers with IIR filters.
module a2d_scheduler
   import a2d_pkg::*;
#(
   parameter logic [2:0] LFT_CH  = 3'd0,
   parameter logic [2:0] RGHT_CH = 3'd4,
   parameter logic [2:0] BATT_CH = 3'd5,
   parameter int         GAP_CYC = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    nxt,
   a2d_scheduler_if.master         spi,
   output logic [11:0]             lft_ld,
   output logic [11:0]             rght_ld,
   output logic [11:0]             batt,
   output logic                    busy,
   output logic                    rnd_vld,
   output a2d_state_t              state
);

   localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);

   a2d_state_t  state_nxt;
   a2d_chan_t   ptr;
   a2d_chan_t   ptr_nxt;
   logic [2:0]  chan_num;
   logic [7:0]  gap_cnt;
   logic        start;
   logic        issue;
   logic        gap_ld;
   logic        latch;
   logic        wrt_q;
   logic [15:0] cmd_q;
   logic [11:0] sample;
   logic        ld_lft;
   logic        ld_rght;
   logic        ld_batt;

   assign spi.wrt = wrt_q;
   assign spi.cmd = cmd_q;
   assign sample  = spi.rd_data[11:0];

   always_comb begin
      chan_num = BATT_CH;
      ptr_nxt  = CH_LFT;
      case (ptr)
         CH_LFT:  begin chan_num = LFT_CH;  ptr_nxt = CH_RGHT; end
         CH_RGHT: begin chan_num = RGHT_CH; ptr_nxt = CH_BATT; end
         default: begin chan_num = BATT_CH; ptr_nxt = CH_LFT;  end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // nxt is only honoured in IDLE; done is only honoured in CNV and RD.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      issue     = 1'b0;
      gap_ld    = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: if (nxt) begin
            start     = 1'b1;
            issue     = 1'b1;
            state_nxt = CNV;
         end
         CNV: if (spi.done) begin
            gap_ld    = 1'b1;
            state_nxt = GAP;
         end
         GAP: if (gap_cnt == 8'd0) begin
            issue     = 1'b1;
            state_nxt = RD;
         end
         RD: if (spi.done) begin
            latch     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= CH_LFT;
         wrt_q   <= 1'b0;
         cmd_q   <= 16'h0000;
         busy    <= 1'b0;
         rnd_vld <= 1'b0;
         gap_cnt <= 8'd0;
      end else begin
         wrt_q   <= issue;
         rnd_vld <= latch && (ptr == CH_BATT);
         if (start) begin
            cmd_q <= a2d_cmd(chan_num);
            busy  <= 1'b1;
         end
         if (gap_ld)
            gap_cnt <= GAP_LD;
         else if (state == GAP && gap_cnt != 8'd0)
            gap_cnt <= gap_cnt - 8'd1;
         if (latch) begin
            busy <= 1'b0;
            ptr  <= ptr_nxt;
         end
      end
   end

   assign ld_lft  = latch && (ptr == CH_LFT);
   assign ld_rght = latch && (ptr == CH_RGHT);
   assign ld_batt = latch && (ptr == CH_BATT);

`ifdef A2D_AVG_EN
   a2d_avg u_avg_lft  (.clk(clk), .rst_n(rst_n), .ld(ld_lft),  .sample(sample), .val(lft_ld));
   a2d_avg u_avg_rght (.clk(clk), .rst_n(rst_n), .ld(ld_rght), .sample(sample), .val(rght_ld));
   a2d_avg u_avg_batt (.clk(clk), .rst_n(rst_n), .ld(ld_batt), .sample(sample), .val(batt));
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_ld  <= 12'h000;
         rght_ld <= 12'h000;
         batt    <= 12'h000;
      end else begin
         if (ld_lft)  lft_ld  <= sample;
         if (ld_rght) rght_ld <= sample;
         if (ld_batt) batt    <= sample;
      end
   end
`endif

endmodule

// File: tb/tb_a2d_scheduler.sv
// Self-checking bench for a2d_scheduler: the bench plays the SPI monarch and predicts results.
module tb_a2d_scheduler;
   import a2d_pkg::*;

   localparam int GAP_CYC = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic nxt = 1'b0;
   always #5 clk = ~clk;

   a2d_scheduler_if spi ();

   logic [11:0] lft_ld, rght_ld, batt;
   logic        busy, rnd_vld;
   a2d_state_t  state;

   a2d_scheduler #(.GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .nxt(nxt), .spi(spi),
      .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
      .busy(busy), .rnd_vld(rnd_vld), .state(state)
   );

   // scoreboard
   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   int          conv_idx;
   logic [11:0] exp_reg[3];
   bit          first_s[3];
   int unsigned ch_num[3] = '{0, 4, 5};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      conv_idx = 0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         exp_reg[i] = 12'h000;
         first_s[i] = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_lft"},  32'(lft_ld),  32'(exp_reg[0]));
      check({tag, "_rght"}, 32'(rght_ld), 32'(exp_reg[1]));
      check({tag, "_batt"}, 32'(batt),    32'(exp_reg[2]));
   endtask

   // driver: one full conversion with the bench acting as SPI monarch
   task automatic run_conv(input logic [11:0] smp, input bit spam);
      int k;
      int n;
      int lat;
      bit cmd_ok;
      bit wrt_ok;
      logic [15:0] ec;
      k = conv_idx % 3;
      exp_q.push_back(16'(ch_num[k] << 11));
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      ec = exp_q.pop_front();
      check("wrt1", 32'(spi.wrt), 32'd1);
      check("busy_rise", 32'(busy), 32'd1);
      check("cmd1", 32'(spi.cmd), 32'(ec));
      cmd_ok = 1'b1;
      wrt_ok = 1'b1;
      lat = $urandom_range(2, 25);
      repeat (lat) begin
         @(negedge clk);
         if (spi.cmd !== ec) cmd_ok = 1'b0;
         if (spi.wrt !== 1'b0 || busy !== 1'b1) wrt_ok = 1'b0;
         if (spam) nxt = ($urandom_range(0, 3) == 0);
      end
      nxt = 1'b0;
      spi.done = 1'b1;
      spi.rd_data = 16'($urandom);
      @(negedge clk) spi.done = 1'b0;
      n = 1;
      while (spi.wrt !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
         spi.done = (spam && n == 2);
      end
      spi.done = 1'b0;
      check("gap_len", 32'(n), 32'(GAP_CYC + 1));
      check("cmd2", 32'(spi.cmd), 32'(ec));
      lat = $urandom_range(2, 25);
      repeat (lat) begin
         @(negedge clk);
         if (spi.cmd !== ec) cmd_ok = 1'b0;
         if (spi.wrt !== 1'b0 || busy !== 1'b1) wrt_ok = 1'b0;
      end
      check("cmd_stable", 32'(cmd_ok), 32'd1);
      check("single_wrt_busy", 32'(wrt_ok), 32'd1);
      spi.done = 1'b1;
      spi.rd_data = {4'($urandom), smp};
      if (spam) nxt = 1'b1;
      @(negedge clk);
      spi.done = 1'b0;
      nxt = 1'b0;
`ifdef A2D_AVG_EN
      exp_reg[k] = first_s[k] ? smp : 12'((3 * int'(exp_reg[k]) + int'(smp)) / 4);
`else
      exp_reg[k] = smp;
`endif
      first_s[k] = 1'b0;
      conv_idx++;
      check("busy_fall", 32'(busy), 32'd0);
      check("rnd_vld", 32'(rnd_vld), 32'(k == 2));
      check_outputs("latch");
      @(negedge clk);
      check("rnd_vld_pulse", 32'(rnd_vld), 32'd0);
      check("no_queue", 32'(spi.wrt), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      spi.done = 1'b0;
      spi.rd_data = 16'h0000;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_wrt", 32'(spi.wrt), 32'd0);
      check("rst_cmd", 32'(spi.cmd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rnd", 32'(rnd_vld), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      check_outputs("rst");
      rst_n = 1'b1;

      // spec values, spaced 2000 clocks
      run_conv(12'h110, 1'b0);
      repeat (2000) @(negedge clk);
      run_conv(12'h100, 1'b0);
      repeat (2000) @(negedge clk);
      run_conv(12'hC00, 1'b0);

      // stray done while idle has no effect
      @(negedge clk) spi.done = 1'b1;
      @(negedge clk) spi.done = 1'b0;
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_wrt", 32'(spi.wrt), 32'd0);
      check("idle_done_state", 32'(state), 32'(IDLE));
      check_outputs("idle_done");

      // round 2 with new lft value, rght/batt as before
      run_conv(12'h0F0, 1'b1);
      run_conv(12'h100, 1'b1);
      run_conv(12'hC00, 1'b1);

      // randomized rounds with nxt spam and spurious done
      for (int r = 0; r < 12; r++) begin
         run_conv(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // finish to a round boundary, then lft, then reset during rght GAP
      while (conv_idx % 3 != 0) run_conv(12'($urandom_range(0, 4095)), 1'b0);
      run_conv(12'($urandom_range(0, 4095)), 1'b0);
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      check("mid_cmd", 32'(spi.cmd), 32'h2000);
      repeat (5) @(negedge clk);
      spi.done = 1'b1;
      @(negedge clk) spi.done = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_wrt", 32'(spi.wrt), 32'd0);
      check("arst_cmd", 32'(spi.cmd), 32'd0);
      check_outputs("arst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_conv(12'($urandom_range(0, 4095)), 1'b0);
      run_conv(12'($urandom_range(0, 4095)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
